axi_dram_slave: RTL and testbench

Cycle-accurate AXI4 slave memory model: the responder end of the DRAM bus that the ISP drives as master. It serves independent INCR read and write bursts of 128-bit beats into a word array. It sits in the testbench/pseudo-DRAM position and must be synthesizable.

---
 rtl/axi_dram_pkg.sv | 20 ++
 rtl/dram_word_array.sv | 23 ++
 rtl/axi_dram_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_dram_slave.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dram_pkg.sv
// Shared constants, FSM state types and request checking for the AXI DRAM slave.
package axi_dram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_16B    = 3'b100;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // A request is unserviceable unless it is a 16-byte aligned INCR burst at or above the base.
  function automatic logic req_err(input logic [2:0]  size,
                                   input logic [1:0]  burst,
                                   input logic [31:0] addr,
                                   input logic [31:0] base);
    return (size != SIZE_16B) || (burst != BURST_INCR) || (addr[3:0] != 4'h0) || (addr < base);
  endfunction

endpackage

// File: rtl/dram_word_array.sv
// DEPTH x 128-bit storage with one asynchronous read port and one synchronous write port.
module dram_word_array #(
  parameter int unsigned DEPTH = 3072,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [127:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [127:0]  rdata
);

  logic [127:0] mem [DEPTH];

  // Write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_dram_slave.sv
// AXI4 slave memory model: independent INCR read and write burst engines over a word array.
module axi_dram_slave
  import axi_dram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h10000,
  parameter int unsigned DEPTH     = 3072,
  parameter int unsigned RD_LAT    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   awid_s_inf,
  input  logic [31:0]  awaddr_s_inf,
  input  logic [2:0]   awsize_s_inf,
  input  logic [1:0]   awburst_s_inf,
  input  logic [7:0]   awlen_s_inf,
  input  logic         awvalid_s_inf,
  output logic         awready_s_inf,
  input  logic [127:0] wdata_s_inf,
  input  logic         wlast_s_inf,
  input  logic         wvalid_s_inf,
  output logic         wready_s_inf,
  output logic [3:0]   bid_s_inf,
  output logic [1:0]   bresp_s_inf,
  output logic         bvalid_s_inf,
  input  logic         bready_s_inf,
  input  logic [3:0]   arid_s_inf,
  input  logic [31:0]  araddr_s_inf,
  input  logic [7:0]   arlen_s_inf,
  input  logic [2:0]   arsize_s_inf,
  input  logic [1:0]   arburst_s_inf,
  input  logic         arvalid_s_inf,
  output logic         arready_s_inf,
  output logic [3:0]   rid_s_inf,
  output logic [127:0] rdata_s_inf,
  output logic [1:0]   rresp_s_inf,
  output logic         rlast_s_inf,
  output logic         rvalid_s_inf,
  input  logic         rready_s_inf
);

  localparam int unsigned AW = $clog2(DEPTH);

  function automatic logic [31:0] base_idx(input logic [31:0] addr);
    return (addr - BASE_ADDR) >> 4;
  endfunction

  // Read channel state
  r_state_t     r_state_q;
  logic [15:0]  r_cnt_q;
  logic [31:0]  r_idx_q;
  logic [7:0]   r_len_q;
  logic [7:0]   r_beat_q;
  logic         r_err_q;
  logic         arready_q, rvalid_q, rlast_q;
  logic [3:0]   rid_q;
  logic [127:0] rdata_q;
  logic [1:0]   rresp_q;

  // Write channel state
  w_state_t     w_state_q;
  logic [31:0]  w_idx_q;
  logic [7:0]   w_len_q;
  logic [7:0]   w_beat_q;
  logic         w_err_q;
  logic [3:0]   w_id_q;
  logic         awready_q, wready_q, bvalid_q;
  logic [3:0]   bid_q;
  logic [1:0]   bresp_q;

  logic [31:0]  r_fetch_idx;
  logic         r_fetch_ok;
  logic [127:0] mem_rdata;
  logic         w_fire, w_beat_err, mem_we;

  // Beat 0 is fetched from the latched index; later beats from the next index.
  always_comb begin
    r_fetch_idx = (r_state_q == R_WAIT) ? r_idx_q : r_idx_q + 32'd1;
    r_fetch_ok  = !r_err_q && (r_fetch_idx < 32'(DEPTH));
  end

  // Write-side beat qualification: out-of-range index or misplaced wlast poisons the burst.
  always_comb begin
    w_fire     = (w_state_q == W_DATA) && wvalid_s_inf && wready_q;
    w_beat_err = (w_idx_q >= 32'(DEPTH)) || (wlast_s_inf != (w_beat_q == w_len_q));
    mem_we     = w_fire && !w_err_q && (w_idx_q < 32'(DEPTH));
  end

  dram_word_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_idx_q[AW-1:0]),
    .wdata (wdata_s_inf),
    .raddr (r_fetch_idx[AW-1:0]),
    .rdata (mem_rdata)
  );

  // Read FSM: accept AR, wait RD_LAT cycles, then stream beats under rready backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid_s_inf && arready_q) begin
            arready_q <= 1'b0;
            rid_q     <= arid_s_inf;
            r_idx_q   <= base_idx(araddr_s_inf);
            r_len_q   <= arlen_s_inf;
            r_err_q   <= req_err(arsize_s_inf, arburst_s_inf, araddr_s_inf, BASE_ADDR);
            r_cnt_q   <= '0;
            r_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt_q == 16'(RD_LAT - 1)) begin
            r_state_q <= R_BURST;
            rvalid_q  <= 1'b1;
            rdata_q   <= r_fetch_ok ? mem_rdata : '0;
            rresp_q   <= r_fetch_ok ? RESP_OKAY : RESP_SLVERR;
            rlast_q   <= (r_len_q == 8'd0);
            r_beat_q  <= '0;
          end else begin
            r_cnt_q <= r_cnt_q + 16'd1;
          end
        end
        R_BURST: begin
          if (rready_s_inf) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rdata_q   <= '0;
              rresp_q   <= '0;
              r_state_q <= R_IDLE;
            end else begin
              r_idx_q  <= r_fetch_idx;
              r_beat_q <= r_beat_q + 8'd1;
              rdata_q  <= r_fetch_ok ? mem_rdata : '0;
              rresp_q  <= r_fetch_ok ? RESP_OKAY : RESP_SLVERR;
              rlast_q  <= ((r_beat_q + 8'd1) == r_len_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Write FSM: accept AW, absorb len+1 beats, then hold the B response until bready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_err_q   <= 1'b0;
      w_id_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid_s_inf && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_id_q    <= awid_s_inf;
            w_idx_q   <= base_idx(awaddr_s_inf);
            w_len_q   <= awlen_s_inf;
            w_beat_q  <= '0;
            w_err_q   <= req_err(awsize_s_inf, awburst_s_inf, awaddr_s_inf, BASE_ADDR);
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx_q  <= w_idx_q + 32'd1;
            w_beat_q <= w_beat_q + 8'd1;
            w_err_q  <= w_err_q || w_beat_err;
            if (w_beat_q == w_len_q) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bid_q     <= w_id_q;
              bresp_q   <= (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready_s_inf) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign arready_s_inf = arready_q;
  assign rvalid_s_inf  = rvalid_q;
  assign rdata_s_inf   = rdata_q;
  assign rresp_s_inf   = rresp_q;
  assign rlast_s_inf   = rlast_q;
  assign rid_s_inf     = rid_q;
  assign awready_s_inf = awready_q;
  assign wready_s_inf  = wready_q;
  assign bvalid_s_inf  = bvalid_q;
  assign bid_s_inf     = bid_q;
  assign bresp_s_inf   = bresp_q;

endmodule

// File: tb/tb_axi_dram_slave.sv
// Directed bench for axi_dram_slave: bursts, backpressure, error responses and reset.
module tb_axi_dram_slave;
  import axi_dram_pkg::*;

  localparam logic [31:0] BASE  = 32'h10000;
  localparam int          DEPTH = 3072;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [7:0]   awlen;
  logic         awvalid, awready;
  logic [127:0] wdata;
  logic         wlast, wvalid, wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;
  logic [127:0] model [DEPTH];

  always #5 clk = ~clk;

  axi_dram_slave #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .RD_LAT    (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .awid_s_inf    (awid),
    .awaddr_s_inf  (awaddr),
    .awsize_s_inf  (awsize),
    .awburst_s_inf (awburst),
    .awlen_s_inf   (awlen),
    .awvalid_s_inf (awvalid),
    .awready_s_inf (awready),
    .wdata_s_inf   (wdata),
    .wlast_s_inf   (wlast),
    .wvalid_s_inf  (wvalid),
    .wready_s_inf  (wready),
    .bid_s_inf     (bid),
    .bresp_s_inf   (bresp),
    .bvalid_s_inf  (bvalid),
    .bready_s_inf  (bready),
    .arid_s_inf    (arid),
    .araddr_s_inf  (araddr),
    .arlen_s_inf   (arlen),
    .arsize_s_inf  (arsize),
    .arburst_s_inf (arburst),
    .arvalid_s_inf (arvalid),
    .arready_s_inf (arready),
    .rid_s_inf     (rid),
    .rdata_s_inf   (rdata),
    .rresp_s_inf   (rresp),
    .rlast_s_inf   (rlast),
    .rvalid_s_inf  (rvalid),
    .rready_s_inf  (rready)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input logic [127:0] dbase, input bit early, input logic [1:0] exp_bresp);
    int n;
    logic [31:0] idx;
    if (early) begin
      wvalid = 1'b1;
      wdata  = dbase;
      wlast  = (len == 8'd0);
      for (int i = 0; i < 3; i++) begin
        check("early_wready", wready, 0);
        step();
      end
    end
    awaddr  = addr;
    awlen   = len;
    awid    = id;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin step(); n++; end
    check("aw_ready", awready, 1);
    if (early) check("early_wready_at_aw", wready, 0);
    step();
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      wdata  = dbase + 128'(k);
      wlast  = (k == int'(len));
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin step(); n++; end
      if (k == 0) check("w_ready", wready, 1);
      idx = ((addr - BASE) >> 4) + 32'(k);
      if (idx < DEPTH) model[idx] = wdata;
      step();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin step(); n++; end
    check("b_valid", bvalid, 1);
    check("b_resp", bresp, exp_bresp);
    check("b_id", bid, id);
    step();
    bready = 1'b0;
    check("b_valid_clear", bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input bit toggle, input bit addr_ok);
    int n, lat, k;
    bit ph, ok;
    logic [31:0] idx;
    araddr  = addr;
    arlen   = len;
    arid    = id;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin step(); n++; end
    check("ar_ready", arready, 1);
    step();
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin step(); lat++; end
    check("rd_latency", lat, 5);
    k  = 0;
    ph = 1'b1;
    n  = 0;
    while (k <= int'(len) && n < 2000) begin
      rready = toggle ? ph : 1'b1;
      check("rd_valid", rvalid, 1);
      if (rvalid) begin
        idx = ((addr - BASE) >> 4) + 32'(k);
        ok  = addr_ok && (idx < DEPTH);
        check("rd_data", rdata, ok ? model[idx] : 128'h0);
        check("rd_stat", {rresp, rlast, rid},
              {(ok ? RESP_OKAY : RESP_SLVERR), (k == int'(len)), id});
        if (rready) k++;
      end
      ph = ~ph;
      step();
      n++;
    end
    rready = 1'b0;
    check("rd_beats", k, int'(len) + 1);
    check("rd_valid_end", rvalid, 0);
    check("ar_ready_gap", arready, 0);
    step();
    check("ar_ready_back", arready, 1);
  endtask

  initial begin
    int n, k;
    rst_n   = 1'b0;
    awid    = '0; awaddr = '0; awsize = SIZE_16B; awburst = BURST_INCR; awlen = '0;
    awvalid = 1'b0; wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid    = '0; araddr = '0; arlen = '0; arsize = SIZE_16B; arburst = BURST_INCR;
    arvalid = 1'b0; rready = 1'b0;
    step();
    step();
    check("rst_arready", arready, 0);
    check("rst_awready", awready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_wready", wready, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_arready", arready, 1);
    check("post_rst_awready", awready, 1);

    do_write(BASE, 8'd191, 4'd1, 128'h0, 1'b0, RESP_OKAY);
    do_write(32'h10C00, 8'd191, 4'd2, 128'h1234_5678_9abc_def0_0000_0000_0000_0000, 1'b1,
             RESP_OKAY);
    do_read(32'h10C00, 8'd191, 4'd3, 1'b1, 1'b1);
    do_read(BASE, 8'd0, 4'd4, 1'b0, 1'b1);
    do_read(BASE + 32'h7F0, 8'd3, 4'd5, 1'b0, 1'b1);
    do_read(32'h10008, 8'd3, 4'd6, 1'b0, 1'b0);
    do_write(32'h1BFF0, 8'd1, 4'd7, 128'hCAFE_0000, 1'b0, RESP_SLVERR);
    do_read(32'h1BFF0, 8'd1, 4'd8, 1'b1, 1'b1);

    // Reset while beat 50 of a 192-beat read is on the bus.
    araddr  = BASE;
    arlen   = 8'd191;
    arid    = 4'd9;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin step(); n++; end
    step();
    arvalid = 1'b0;
    rready  = 1'b1;
    k = 0;
    n = 0;
    while (k < 50 && n < 400) begin
      if (rvalid) k++;
      step();
      n++;
    end
    check("rst_mid_valid", rvalid, 1);
    check("rst_mid_beat50", rdata, model[50]);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", rvalid, 0);
    check("rst_mid_rdata", rdata, 0);
    check("rst_mid_arready", arready, 0);
    rready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_rel_arready", arready, 1);
    check("rst_rel_rvalid", rvalid, 0);
    do_read(BASE, 8'd3, 4'd10, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
